encode_job_ctl: RTL and testbench
=================================

Name: encode_job_ctl

Overview:
- Job-level sequencer in front of the LZS `encode` core.
- Accepts one compression job descriptor at a time, clears the core, then enables it.
- Meters source words into the core and flags the last word; waits for end-of-stream, counts output words and returns a completion record.
- Runs a watchdog so a hung core cannot stall the job queue.

Parameters:
- LZF_WIDTH, 20, width of byte-length fields; matches the core's fi_cnt.
- CLR_CYCLES, 4, cycles the core reset is held at job start (1..15).
- TIMEOUT, 65535, idle cycles in RUN/DRAIN before a job is aborted (16-bit).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- job_valid  in  1  descriptor valid.
- job_ready  out  1  descriptor accepted when valid&ready.
- job_len  in  LZF_WIDTH  job length in bytes.
- job_id  in  8  tag echoed on completion.
- src_empty_i  in  1  upstream source FIFO empty.
- enc_src_empty  out  1  gated empty to the core.
- enc_rst  out  1  active-high reset to the core.
- enc_ce  out  1  core clock enable.
- enc_fi_cnt  out  LZF_WIDTH  remaining source bytes.
- enc_m_last  out  1  current head word is the job's last.
- enc_src_getn  in  1  core source-word pop, active low.
- enc_dst_putn  in  1  core output-word push, active low.
- enc_endn  in  1  core end-of-stream, active low.
- done_valid  out  1  completion record valid.
- done_ready  in  1  completion record consumed.
- done_id  out  8  job tag.
- done_out_words  out  16  output words produced, saturating.
- done_err  out  1  job aborted by watchdog.
- busy  out  1  state != IDLE.

Behaviour:

Reset (rst==0 at an edge):
- State goes to IDLE.
- All counters are 0.
- enc_rst=1, enc_ce=0, enc_src_empty=1, enc_m_last=0, enc_fi_cnt=0.
- job_ready=0, done_valid=0, done_id=0, done_out_words=0, done_err=0, busy=0.
- Asserting rst mid-job aborts the job; no completion record is produced.
- All outputs are registered.

States are IDLE, CLR, RUN, DRAIN, DONE.

IDLE:
- job_ready=1, enc_rst=0, enc_ce=0.
- On job_valid&job_ready, latch len, id and rem_w=ceil(len/8). Set rem_b=len and enc_fi_cnt=len.
- len==0: go to DONE with words=0, err=0; the core is never touched.
- Otherwise go to CLR.

CLR:
- enc_rst=1 for exactly CLR_CYCLES cycles, enc_ce=0, out_words cleared, watchdog cleared; then go to RUN.
- Timing: job accepted at edge N → enc_rst high N+1..N+CLR_CYCLES; enc_ce high from N+CLR_CYCLES+1.

RUN:
- enc_ce=1; enc_src_empty = src_empty_i | (rem_w==0).
- Each cycle with enc_src_getn==0 and rem_w!=0:
  - rem_w -= 1.
  - rem_b -= min(8, rem_b).
  - enc_fi_cnt follows rem_b.
- enc_m_last = (rem_w==1).
- A getn pulse with rem_w==0 is ignored.
- When rem_w reaches 0, go to DRAIN.
- If enc_endn==0 in any RUN cycle, including the cycle of the final pop, go directly to DONE.

DRAIN:
- enc_ce=1, enc_src_empty=1, enc_m_last=0.
- On enc_endn==0, go to DONE with err=0.

Output counting:
- In RUN and DRAIN, each enc_dst_putn==0 cycle increments out_words, saturating at 16'hFFFF.

Watchdog (RUN and DRAIN):
- The 16-bit counter clears on any cycle with getn==0, putn==0 or endn==0; otherwise it increments.
- On reaching TIMEOUT, go to DONE with err=1.

DONE:
- enc_ce=0, enc_src_empty=1.
- done_valid=1 and the done_* fields stay stable until done_valid&done_ready.
- Then go to IDLE; job_ready rises the following cycle.
- A job_valid present in the same cycle as done_ready is not accepted until IDLE.
- Single job in flight; never more than one completion outstanding.

Test Plan:
1. Reset mid-job: rst low one cycle during RUN → next cycle state IDLE, busy=0, enc_rst=1, done_valid never asserted.
2. job_len=20, id=0x5A; the core pops 3 words, puts 2, endn low 4 cycles later:
   - enc_rst high for exactly 4 cycles.
   - enc_fi_cnt sequence 20→12→4→0.
   - enc_m_last high only while rem_w==1.
   - done_id=0x5A, done_out_words=2, done_err=0.
3. job_len=0 → done_valid within 2 cycles of acceptance, words=0, enc_ce never high, enc_rst never pulsed.
4. Final pop and endn low in the same cycle (len=8) → DRAIN skipped, done_valid next cycle, err=0.
5. TIMEOUT=16, the core stalls after 1 pop → done_err=1 exactly 16 idle cycles later; done_valid held while done_ready=0 for 10 cycles, fields stable throughout.
6. Back-to-back jobs: job_valid held continuously → second acceptance exactly 1 cycle after the done handshake; out_words restarts from 0.

Source files
------------

// File: rtl/encode_job_ctl.sv
// Job sequencer for the LZS encode core: takes one descriptor, clears and runs the core,
// meters source words, counts output words and returns a completion record.
module encode_job_ctl #(
   parameter int          LZF_WIDTH  = 20,
   parameter int          CLR_CYCLES = 4,
   parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 job_valid,
   output logic                 job_ready,
   input  logic [LZF_WIDTH-1:0] job_len,
   input  logic [7:0]           job_id,
   input  logic                 src_empty_i,
   output logic                 enc_src_empty,
   output logic                 enc_rst,
   output logic                 enc_ce,
   output logic [LZF_WIDTH-1:0] enc_fi_cnt,
   output logic                 enc_m_last,
   input  logic                 enc_src_getn,
   input  logic                 enc_dst_putn,
   input  logic                 enc_endn,
   output logic                 done_valid,
   input  logic                 done_ready,
   output logic [7:0]           done_id,
   output logic [15:0]          done_out_words,
   output logic                 done_err,
   output logic                 busy
);

   typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, DONE} state_e;

   state_e                 state_q, state_d;
   logic [7:0]             id_q, id_d;
   logic [LZF_WIDTH-1:0]   rem_w_q, rem_w_d;
   logic [LZF_WIDTH-1:0]   rem_b_q, rem_b_d;
   logic [3:0]             clr_cnt_q, clr_cnt_d;
   logic [15:0]            wd_q, wd_d;
   logic [15:0]            words_q, words_d;
   logic [7:0]             done_id_q, done_id_d;
   logic [15:0]            done_words_q, done_words_d;
   logic                   done_err_q, done_err_d;
   logic                   job_ready_q, enc_rst_q, enc_ce_q, enc_src_empty_q;
   logic                   enc_m_last_q, done_valid_q, busy_q;
   logic                   job_ready_d, enc_rst_d, enc_ce_d, enc_src_empty_d;
   logic                   enc_m_last_d, done_valid_d, busy_d;
   logic                   finish, err_flag, pop, activity;
   logic [LZF_WIDTH:0]     len_plus7;

   assign pop       = !enc_src_getn && (rem_w_q != '0);
   assign activity  = !enc_src_getn || !enc_dst_putn || !enc_endn;
   assign len_plus7 = {1'b0, job_len} + (LZF_WIDTH+1)'(7);

   // Next-state logic; completion fields are captured on the cycle the job finishes.
   always_comb begin
      state_d      = state_q;
      id_d         = id_q;
      rem_w_d      = rem_w_q;
      rem_b_d      = rem_b_q;
      clr_cnt_d    = clr_cnt_q;
      wd_d         = wd_q;
      words_d      = words_q;
      done_id_d    = done_id_q;
      done_words_d = done_words_q;
      done_err_d   = done_err_q;
      finish       = 1'b0;
      err_flag     = 1'b0;

      case (state_q)
         IDLE: begin
            if (job_valid && job_ready_q) begin
               id_d      = job_id;
               rem_b_d   = job_len;
               rem_w_d   = LZF_WIDTH'(len_plus7 >> 3);
               words_d   = '0;
               clr_cnt_d = '0;
               if (job_len == '0) begin
                  state_d = DONE;
                  finish  = 1'b1;
               end else begin
                  state_d = CLR;
               end
            end
         end
         CLR: begin
            words_d   = '0;
            wd_d      = '0;
            clr_cnt_d = clr_cnt_q + 4'd1;
            if (clr_cnt_q == 4'(CLR_CYCLES - 1)) state_d = RUN;
         end
         RUN, DRAIN: begin
            if (!enc_dst_putn && (words_q != 16'hFFFF)) words_d = words_q + 16'd1;
            wd_d = activity ? 16'd0 : wd_q + 16'd1;
            if ((state_q == RUN) && pop) begin
               rem_w_d = rem_w_q - LZF_WIDTH'(1);
               rem_b_d = (rem_b_q >= LZF_WIDTH'(8)) ? rem_b_q - LZF_WIDTH'(8) : '0;
            end
            if (!enc_endn) begin
               state_d = DONE;
               finish  = 1'b1;
            end else if (wd_d == TIMEOUT) begin
               state_d  = DONE;
               finish   = 1'b1;
               err_flag = 1'b1;
            end else if ((state_q == RUN) && (rem_w_d == '0)) begin
               state_d = DRAIN;
            end
         end
         DONE: begin
            if (done_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (finish) begin
         done_id_d    = id_d;
         done_words_d = words_d;
         done_err_d   = err_flag;
      end

      job_ready_d     = (state_d == IDLE);
      enc_rst_d       = (state_d == CLR);
      enc_ce_d        = (state_d == RUN) || (state_d == DRAIN);
      enc_src_empty_d = (state_d != RUN) || src_empty_i || (rem_w_d == '0);
      enc_m_last_d    = (state_d == RUN) && (rem_w_d == LZF_WIDTH'(1));
      done_valid_d    = (state_d == DONE);
      busy_d          = (state_d != IDLE);
   end

   // Every output is a register loaded from the next-state decode.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q         <= IDLE;
         id_q            <= '0;
         rem_w_q         <= '0;
         rem_b_q         <= '0;
         clr_cnt_q       <= '0;
         wd_q            <= '0;
         words_q         <= '0;
         done_id_q       <= '0;
         done_words_q    <= '0;
         done_err_q      <= 1'b0;
         job_ready_q     <= 1'b0;
         enc_rst_q       <= 1'b1;
         enc_ce_q        <= 1'b0;
         enc_src_empty_q <= 1'b1;
         enc_m_last_q    <= 1'b0;
         done_valid_q    <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         id_q            <= id_d;
         rem_w_q         <= rem_w_d;
         rem_b_q         <= rem_b_d;
         clr_cnt_q       <= clr_cnt_d;
         wd_q            <= wd_d;
         words_q         <= words_d;
         done_id_q       <= done_id_d;
         done_words_q    <= done_words_d;
         done_err_q      <= done_err_d;
         job_ready_q     <= job_ready_d;
         enc_rst_q       <= enc_rst_d;
         enc_ce_q        <= enc_ce_d;
         enc_src_empty_q <= enc_src_empty_d;
         enc_m_last_q    <= enc_m_last_d;
         done_valid_q    <= done_valid_d;
         busy_q          <= busy_d;
      end
   end

   assign job_ready      = job_ready_q;
   assign enc_rst        = enc_rst_q;
   assign enc_ce         = enc_ce_q;
   assign enc_src_empty  = enc_src_empty_q;
   assign enc_fi_cnt     = rem_b_q;
   assign enc_m_last     = enc_m_last_q;
   assign done_valid     = done_valid_q;
   assign done_id        = done_id_q;
   assign done_out_words = done_words_q;
   assign done_err       = done_err_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_encode_job_ctl.sv
// Directed bench for encode_job_ctl: reset, normal jobs, zero-length, early end,
// watchdog abort with held completion, back-to-back jobs and mid-job reset.
module tb_encode_job_ctl;

   logic        clk = 1'b0;
   logic        rst;
   logic        job_valid, job_ready;
   logic [19:0] job_len;
   logic [7:0]  job_id;
   logic        src_empty_i, enc_src_empty, enc_rst, enc_ce, enc_m_last;
   logic [19:0] enc_fi_cnt;
   logic        enc_src_getn, enc_dst_putn, enc_endn;
   logic        done_valid, done_ready, done_err, busy;
   logic [7:0]  done_id;
   logic [15:0] done_out_words;

   int checks = 0;
   int errors = 0;
   int rstCnt;

   encode_job_ctl #(.LZF_WIDTH(20), .CLR_CYCLES(4), .TIMEOUT(16'd16)) dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len), .job_id(job_id),
      .src_empty_i(src_empty_i), .enc_src_empty(enc_src_empty), .enc_rst(enc_rst),
      .enc_ce(enc_ce), .enc_fi_cnt(enc_fi_cnt), .enc_m_last(enc_m_last),
      .enc_src_getn(enc_src_getn), .enc_dst_putn(enc_dst_putn), .enc_endn(enc_endn),
      .done_valid(done_valid), .done_ready(done_ready), .done_id(done_id),
      .done_out_words(done_out_words), .done_err(done_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic getn, input logic putn, input logic endn);
      enc_src_getn = getn;
      enc_dst_putn = putn;
      enc_endn     = endn;
      tick();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic acceptJob(input logic [19:0] len, input logic [7:0] id);
      job_valid = 1'b1;
      job_len   = len;
      job_id    = id;
      tick();
      job_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL global_timeout");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      rst = 1'b0; job_valid = 1'b0; job_len = '0; job_id = '0; src_empty_i = 1'b0;
      enc_src_getn = 1'b1; enc_dst_putn = 1'b1; enc_endn = 1'b1; done_ready = 1'b0;
      tick(); tick();

      // reset state
      checkOutput("rst_enc_rst", enc_rst, 1);
      checkOutput("rst_enc_ce", enc_ce, 0);
      checkOutput("rst_src_empty", enc_src_empty, 1);
      checkOutput("rst_m_last_fi", {enc_m_last, enc_fi_cnt}, 0);
      checkOutput("rst_ready_valid_busy", {job_ready, done_valid, busy}, 0);
      checkOutput("rst_done_fields", {done_id, done_out_words, done_err}, 0);
      rst = 1'b1;
      tick();
      checkOutput("idle_job_ready", job_ready, 1);
      checkOutput("idle_enc_rst", enc_rst, 0);

      // len=20, id=5A: three pops, two puts, end four cycles after last pop
      acceptJob(20'd20, 8'h5A);
      checkOutput("t2_accept_busy_ready", {busy, job_ready}, 2'b10);
      checkOutput("t2_fi_init", enc_fi_cnt, 20);
      rstCnt = 0;
      for (int i = 0; i < 10 && enc_rst; i++) begin
         checkOutput("t2_ce_during_clr", enc_ce, 0);
         rstCnt++;
         tick();
      end
      checkOutput("t2_rst_cycles", rstCnt, 4);
      checkOutput("t2_ce_after_clr", enc_ce, 1);
      checkOutput("t2_src_empty_run", enc_src_empty, 0);
      checkOutput("t2_mlast_0", enc_m_last, 0);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("t2_fi_pop1", enc_fi_cnt, 12);
      checkOutput("t2_mlast_1", enc_m_last, 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("t2_fi_pop2", enc_fi_cnt, 4);
      checkOutput("t2_mlast_2", enc_m_last, 1);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("t2_mlast_hold", enc_m_last, 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("t2_fi_pop3", enc_fi_cnt, 0);
      checkOutput("t2_mlast_3", enc_m_last, 0);
      checkOutput("t2_src_empty_drain", enc_src_empty, 1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("t2_extra_getn_ignored", enc_fi_cnt, 0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("t2_not_done_yet", done_valid, 0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      enc_endn = 1'b1;
      checkOutput("t2_done_valid", done_valid, 1);
      checkOutput("t2_done_id", done_id, 8'h5A);
      checkOutput("t2_done_words", done_out_words, 2);
      checkOutput("t2_done_err", done_err, 0);
      checkOutput("t2_done_ce", enc_ce, 0);
      tick();
      checkOutput("t2_done_held", done_valid, 1);
      done_ready = 1'b1;
      tick();
      done_ready = 1'b0;
      checkOutput("t2_handshake", {done_valid, job_ready, busy}, 3'b010);

      // zero-length job never touches the core
      acceptJob(20'd0, 8'h33);
      checkOutput("t3_done_valid", done_valid, 1);
      checkOutput("t3_core_idle", {enc_rst, enc_ce}, 0);
      checkOutput("t3_fields", {done_id, done_out_words, done_err}, {8'h33, 16'd0, 1'b0});
      done_ready = 1'b1;
      tick();
      done_ready = 1'b0;
      checkOutput("t3_handshake", done_valid, 0);

      // len=8: final pop and end in the same cycle skip DRAIN
      acceptJob(20'd8, 8'h44);
      tick(); tick(); tick(); tick();
      checkOutput("t4_ce", enc_ce, 1);
      checkOutput("t4_mlast", enc_m_last, 1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("t4_done", {done_valid, done_err, done_id}, {1'b1, 1'b0, 8'h44});
      done_ready = 1'b1;
      tick();
      done_ready = 1'b0;

      // watchdog: one pop then stall
      acceptJob(20'd24, 8'h55);
      tick(); tick(); tick(); tick();
      applyStimulus(1'b0, 1'b1, 1'b1);
      enc_src_getn = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         checkOutput("t5_no_early_timeout", done_valid, 0);
      end
      tick();
      checkOutput("t5_timeout", {done_valid, done_err, done_id, done_out_words},
                  {1'b1, 1'b1, 8'h55, 16'd0});
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("t5_held_stable", {done_valid, done_err, done_id, done_out_words},
                     {1'b1, 1'b1, 8'h55, 16'd0});
      end
      done_ready = 1'b1;
      tick();
      done_ready = 1'b0;
      checkOutput("t5_released", done_valid, 0);

      // back-to-back jobs with job_valid held high
      job_valid = 1'b1; job_len = 20'd8; job_id = 8'h61;
      tick();
      tick(); tick(); tick(); tick();
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      enc_src_getn = 1'b1; enc_endn = 1'b1;
      checkOutput("t6_first_done", {done_valid, done_id, done_out_words}, {1'b1, 8'h61, 16'd2});
      job_id = 8'h62;
      done_ready = 1'b1;
      tick();
      done_ready = 1'b0;
      checkOutput("t6_not_taken_at_handshake", {busy, job_ready}, 2'b01);
      tick();
      checkOutput("t6_second_accept", {busy, enc_rst, job_ready}, 3'b110);
      job_valid = 1'b0;
      tick(); tick(); tick(); tick();
      applyStimulus(1'b0, 1'b1, 1'b0);
      enc_src_getn = 1'b1; enc_endn = 1'b1;
      checkOutput("t6_second_done", {done_valid, done_id, done_out_words}, {1'b1, 8'h62, 16'd0});
      done_ready = 1'b1;
      tick();
      done_ready = 1'b0;

      // reset in the middle of RUN
      acceptJob(20'd16, 8'h11);
      tick(); tick(); tick(); tick();
      applyStimulus(1'b0, 1'b1, 1'b1);
      enc_src_getn = 1'b1;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checkOutput("t1_after_reset", {busy, enc_rst, enc_ce, done_valid}, 4'b0100);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("t1_no_completion", {done_valid, busy}, 0);
      end
      checkOutput("t1_ready_again", job_ready, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
